pulse_width_meter: RTL and testbench

//  Multi-channel pulse-width measurement. Each channel times how long its input is active, in clk cycles.

---
 rtl/pulse_width_meter_pkg.sv | 37 +++
 rtl/pulse_width_chan.sv | 143 ++++++++++++++
 rtl/pulse_width_meter.sv | 162 ++++++++++++++++
 tb/tb_pulse_width_meter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_width_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_width_meter_pkg
//   Shared constants and helpers for the pulse width meter.
//   - FACTOR_CM_50M : count -> cm of ultrasonic echo at 50 MHz (FRAC_W = 32).
//                     One 20 ns cycle of round-trip echo is 20e-9 * 17150 cm,
//                     and 3.43e-4 * 2^32 = 1473174.
//   - FACTOR_US_50M : count -> microseconds at 50 MHz (count/50, FRAC_W = 32).
//   - chan_state_t / ST_* : per-channel arm FSM encoding.
//   - clog2 / ch_width : width helpers for the channel index.
// -----------------------------------------------------------------------------
package pulse_width_meter_pkg;

    localparam logic [31:0] FACTOR_CM_50M = 32'd1473174;
    localparam logic [31:0] FACTOR_US_50M = 32'd85899346;

    typedef logic [1:0] chan_state_t;

    localparam chan_state_t ST_DISARMED = 2'd0;
    localparam chan_state_t ST_IDLE     = 2'd1;
    localparam chan_state_t ST_COUNT    = 2'd2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pulse_width_chan.sv
// -----------------------------------------------------------------------------
// pulse_width_chan
//   One measurement channel: 2-flop synchroniser plus edge-detect flop, arm
//   FSM with saturating cycle counter, and a one-entry pending result slot
//   with a sticky overrun flag.
// Ports
//   clk, reset  : system clock, asynchronous active-high reset
//   en          : global measurement enable (0 disarms, partial count dropped)
//   pulse       : raw asynchronous pulse input
//   grant       : arbiter takes the pending slot this cycle
//   clr_ovr     : clears the overrun flag (a simultaneous set wins)
//   full        : pending slot holds a result
//   slot_cnt    : pending raw count
//   slot_ovf    : pending counter-saturated flag
//   overrun     : sticky, a result was dropped because the slot was full
// -----------------------------------------------------------------------------
module pulse_width_chan
    import pulse_width_meter_pkg::*;
#(
    parameter int CNT_W    = 24,
    parameter bit ACT_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pulse,
    input  logic             grant,
    input  logic             clr_ovr,
    output logic             full,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             slot_ovf,
    output logic             overrun
);

    localparam logic             ACT_LVL = ACT_HIGH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        sync_meta;
    logic        sync_lvl;
    logic        sync_prev;
    logic [1:0]  warm;
    chan_state_t state;
    logic [CNT_W-1:0] count;
    logic        ovf;

    logic s_act;
    logic prev_act;
    logic rise;
    logic fall;
    logic capture;

    // The synchroniser powers up at the inactive level, so for two cycles
    // after reset it does not yet reflect the pad. warm gates the arm FSM
    // until the real level has arrived, so a pulse already active at reset
    // release is seen as active and discarded.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= ~ACT_LVL;
            sync_lvl  <= ~ACT_LVL;
            sync_prev <= ~ACT_LVL;
            warm      <= 2'b00;
        end else begin
            sync_meta <= pulse;
            sync_lvl  <= sync_meta;
            sync_prev <= sync_lvl;
            warm      <= {warm[0], 1'b1};
        end
    end

    assign s_act    = (sync_lvl == ACT_LVL);
    assign prev_act = (sync_prev == ACT_LVL);
    assign rise     = s_act && !prev_act;
    assign fall     = !s_act && prev_act;
    assign capture  = en && (state == ST_COUNT) && fall;

    // Arm FSM and saturating counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_DISARMED;
            count <= '0;
            ovf   <= 1'b0;
        end else if (!en) begin
            state <= ST_DISARMED;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_DISARMED: begin
                    if (warm[1] && !s_act) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_COUNT;
                        count <= CNT_W'(1);
                        ovf   <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (fall) begin
                        state <= ST_IDLE;
                    end else if (count == CNT_MAX) begin
                        ovf <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: state <= ST_DISARMED;
            endcase
        end
    end

    // Pending slot. A granted slot is empty as of the grant edge, so a capture
    // on that same edge is accepted rather than dropped.
    // NOTE: the slot is a single register, not a RAM, so it is cleared by
    // reset like any other state; no stale result can survive a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full     <= 1'b0;
            slot_cnt <= '0;
            slot_ovf <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (capture && (!full || grant)) begin
                full     <= 1'b1;
                slot_cnt <= count;
                slot_ovf <= ovf;
            end else if (grant) begin
                full <= 1'b0;
            end

            if (capture && full && !grant) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// -----------------------------------------------------------------------------
// pulse_width_meter
//   Multi-channel pulse width meter. Each channel times how long its input is
//   active; completed pulses are merged by a round-robin arbiter, scaled to
//   engineering units ((cnt*FACTOR)>>FRAC_W, saturated to LEN_W bits) in one
//   registered stage, and presented on a valid/ready output register.
// Ports
//   clk, reset : system clock, asynchronous active-high reset
//   en         : global measurement enable
//   pulse      : raw asynchronous pulse inputs, one per channel
//   out_valid / out_ready : result handshake
//   out_ch     : channel of the result
//   out_cnt    : raw active-cycle count
//   out_len    : scaled length
//   out_ovf    : counter saturated during this pulse
//   overrun    : sticky per-channel dropped-result flags
//   clr_ovr    : clears all overrun flags
// -----------------------------------------------------------------------------
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 24,
    parameter int          LEN_W    = 10,
    parameter logic [31:0] FACTOR   = FACTOR_CM_50M,
    parameter int          FRAC_W   = 32,
    parameter bit          ACT_HIGH = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [NUM_CH-1:0]           pulse,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ch_width(NUM_CH)-1:0] out_ch,
    output logic [CNT_W-1:0]            out_cnt,
    output logic [LEN_W-1:0]            out_len,
    output logic                        out_ovf,
    output logic [NUM_CH-1:0]           overrun,
    input  logic                        clr_ovr
);

    localparam int CH_W   = ch_width(NUM_CH);
    localparam int PROD_W = CNT_W + 32;
    localparam logic [PROD_W-1:0] LEN_MAX_W = {{(PROD_W-LEN_W){1'b0}}, {LEN_W{1'b1}}};

    logic [NUM_CH-1:0] slot_full;
    logic [CNT_W-1:0]  slot_cnt [NUM_CH];
    logic [NUM_CH-1:0] slot_ovf;
    logic [NUM_CH-1:0] grant;

    logic [CH_W-1:0]   last_ch;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_idx;
    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_ovf;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] shifted;
    logic [LEN_W-1:0]  sel_len;
    logic              o_free;
    logic              take;

    logic              s_vld;
    logic [CH_W-1:0]   s_ch;
    logic [CNT_W-1:0]  s_cnt;
    logic [LEN_W-1:0]  s_len;
    logic              s_ovf;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        pulse_width_chan #(
            .CNT_W    (CNT_W),
            .ACT_HIGH (ACT_HIGH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .pulse    (pulse[g]),
            .grant    (grant[g]),
            .clr_ovr  (clr_ovr),
            .full     (slot_full[g]),
            .slot_cnt (slot_cnt[g]),
            .slot_ovf (slot_ovf[g]),
            .overrun  (overrun[g])
        );
    end

    // Round-robin: search starts at the channel after the last grant.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_cnt   = '0;
        sel_ovf   = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = (int'(last_ch) + i) % NUM_CH;
            if (!gnt_found && slot_full[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(cand);
                sel_cnt   = slot_cnt[cand];
                sel_ovf   = slot_ovf[cand];
            end
        end
    end

    // The scale stage always drains into the output register on the same
    // condition that allows a grant, so the pipeline holds at most one
    // result beyond the pending slots while the consumer stalls.
    assign o_free = !out_valid || out_ready;
    assign take   = gnt_found && o_free;
    assign grant  = take ? (NUM_CH'(1) << gnt_idx) : '0;

    always_comb begin
        prod    = PROD_W'(sel_cnt) * PROD_W'(FACTOR);
        shifted = prod >> FRAC_W;
        sel_len = (shifted > LEN_MAX_W) ? {LEN_W{1'b1}} : shifted[LEN_W-1:0];
    end

    // Scale stage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_ch <= CH_W'(NUM_CH - 1);
            s_vld   <= 1'b0;
            s_ch    <= '0;
            s_cnt   <= '0;
            s_len   <= '0;
            s_ovf   <= 1'b0;
        end else if (o_free) begin
            s_vld <= take;
            if (take) begin
                last_ch <= gnt_idx;
                s_ch    <= gnt_idx;
                s_cnt   <= sel_cnt;
                s_len   <= sel_len;
                s_ovf   <= sel_ovf;
            end
        end
    end

    // Output register: loads only when empty or accepted, so all out_* hold
    // while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_cnt   <= '0;
            out_len   <= '0;
            out_ovf   <= 1'b0;
        end else if (o_free) begin
            out_valid <= s_vld;
            if (s_vld) begin
                out_ch  <= s_ch;
                out_cnt <= s_cnt;
                out_len <= s_len;
                out_ovf <= s_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_width_meter
//   Directed bench for pulse_width_meter. Main instance uses default
//   parameters; a second single-channel, active-low instance with CNT_W=8,
//   LEN_W=4 and FACTOR=2^32-1 exercises counter and length saturation.
// -----------------------------------------------------------------------------
module tb_pulse_width_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  pulse;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [23:0] out_cnt;
    logic [9:0]  out_len;
    logic        out_ovf;
    logic [3:0]  overrun;
    logic        clr_ovr;

    logic [0:0]  pulse8;
    logic        out_valid8;
    logic        out_ready8;
    logic [0:0]  out_ch8;
    logic [7:0]  out_cnt8;
    logic [3:0]  out_len8;
    logic        out_ovf8;
    logic [0:0]  overrun8;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    pulse_width_meter dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .pulse     (pulse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_cnt   (out_cnt),
        .out_len   (out_len),
        .out_ovf   (out_ovf),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
    );

    pulse_width_meter #(
        .NUM_CH   (1),
        .CNT_W    (8),
        .LEN_W    (4),
        .FACTOR   (32'hFFFF_FFFF),
        .FRAC_W   (32),
        .ACT_HIGH (1'b0)
    ) dut8 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .pulse     (pulse8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_ch    (out_ch8),
        .out_cnt   (out_cnt8),
        .out_len   (out_len8),
        .out_ovf   (out_ovf8),
        .overrun   (overrun8),
        .clr_ovr   (clr_ovr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Raw input sampled active on exactly n rising edges.
    task automatic drive_pulse(input logic [3:0] mask, input int n);
        @(posedge clk);
        #2;
        pulse = mask;
        repeat (n) @(posedge clk);
        #2;
        pulse = 4'b0000;
    endtask

    task automatic drive_pulse8(input int n);
        @(posedge clk);
        #2;
        pulse8 = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        pulse8 = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check(tag, out_valid, 1);
    endtask

    task automatic wait_valid8(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid8) break;
        end
        check(tag, out_valid8, 1);
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
    endtask

    task automatic check_result(input string tag, input int ch, input int cnt,
                                input int len, input int ovf);
        check({tag, ".ch"},  out_ch,  ch);
        check({tag, ".cnt"}, out_cnt, cnt);
        check({tag, ".len"}, out_len, len);
        check({tag, ".ovf"}, out_ovf, ovf);
    endtask

    // order holds the expected channel sequence, 2 bits per result, first in LSBs.
    task automatic check_burst(input string tag, input int n, input logic [7:0] order,
                               input int cnt);
        wait_valid({tag, ".start"}, 20);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s.valid%0d", tag, k), out_valid, 1);
            check($sformatf("%s.ch%0d", tag, k), out_ch, order[2*k +: 2]);
            check($sformatf("%s.cnt%0d", tag, k), out_cnt, cnt);
            @(negedge clk);
        end
        check({tag, ".end"}, out_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b1;
        en         = 1'b0;
        pulse      = 4'b0000;
        pulse8     = 1'b1;
        out_ready  = 1'b1;
        out_ready8 = 1'b1;
        clr_ovr    = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst.valid",   out_valid, 0);
        check("rst.ch",      out_ch,    0);
        check("rst.cnt",     out_cnt,   0);
        check("rst.len",     out_len,   0);
        check("rst.ovf",     out_ovf,   0);
        check("rst.overrun", overrun,   0);
        check("rst.valid8",  out_valid8, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        en    = 1'b1;
        tick(5);

        // 1: scale boundary around one cm, plus exact latency
        drive_pulse(4'b0001, 2916);
        repeat (5) @(negedge clk);
        check("t1.lat_e3", out_valid, 0);
        @(negedge clk);
        check("t1.lat_e4", out_valid, 1);
        check_result("t1a", 0, 2916, 1, 0);
        @(negedge clk);
        check("t1.drop", out_valid, 0);
        drive_pulse(4'b0001, 2915);
        wait_valid("t1b.wait", 20);
        check_result("t1b", 0, 2915, 0, 0);

        // 2: ten cm on channel 2, then counter and length saturation
        drive_pulse(4'b0100, 29155);
        wait_valid("t2a.wait", 20);
        check_result("t2a", 2, 29155, 10, 0);
        drive_pulse8(300);
        wait_valid8("t2b.wait", 20);
        check("t2b.ch",  out_ch8,  0);
        check("t2b.cnt", out_cnt8, 255);
        check("t2b.ovf", out_ovf8, 1);
        check("t2b.len", out_len8, 15);
        drive_pulse8(5);
        wait_valid8("t2c.wait", 20);
        check("t2c.cnt", out_cnt8, 5);
        check("t2c.ovf", out_ovf8, 0);
        check("t2c.len", out_len8, 4);

        // 3: simultaneous pulses and round-robin continuation
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
        drive_pulse(4'b1111, 7);
        check_burst("t3a", 4, 8'b11_10_01_00, 7);
        drive_pulse(4'b0110, 8);
        check_burst("t3b", 2, 8'b00_00_10_01, 8);
        drive_pulse(4'b1111, 9);
        check_burst("t3c", 4, 8'b10_01_00_11, 9);

        // 4: back-pressure, pending slot, overrun and clear
        out_ready = 1'b0;
        drive_pulse(4'b0010, 10);
        wait_valid("t4a.wait", 20);
        check_result("t4a", 1, 10, 0, 0);
        drive_pulse(4'b0010, 20);
        tick(8);
        @(negedge clk);
        check("t4.hold_valid", out_valid, 1);
        check("t4.hold_cnt",   out_cnt,   10);
        check("t4.no_ovr",     overrun,   0);
        drive_pulse(4'b0010, 30);
        tick(8);
        @(negedge clk);
        check("t4.ovr",       overrun, 4'b0010);
        check("t4.hold_cnt2", out_cnt, 10);
        out_ready = 1'b1;
        wait_valid("t4b.wait", 20);
        check_result("t4b", 1, 20, 0, 0);
        count_valid(12, n);
        check("t4.no_third", n, 0);
        check("t4.ovr_sticky", overrun, 4'b0010);
        @(posedge clk);
        #2;
        clr_ovr = 1'b1;
        @(posedge clk);
        #2;
        clr_ovr = 1'b0;
        @(negedge clk);
        check("t4.ovr_clr", overrun, 0);

        // 5: pulse through reset release, then en dropped mid-pulse
        pulse = 4'b0001;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(20);
        pulse = 4'b0000;
        count_valid(15, n);
        check("t5.rst_pulse", n, 0);
        drive_pulse(4'b0001, 50);
        wait_valid("t5a.wait", 20);
        check_result("t5a", 0, 50, 0, 0);
        @(posedge clk);
        #2;
        pulse = 4'b0001;
        tick(10);
        en = 1'b0;
        tick(5);
        en = 1'b1;
        tick(10);
        pulse = 4'b0000;
        count_valid(15, n);
        check("t5.en_pulse", n, 0);
        drive_pulse(4'b0001, 12);
        wait_valid("t5b.wait", 20);
        check_result("t5b", 0, 12, 0, 0);

        // 6: asynchronous reset while a result is held
        out_ready = 1'b0;
        drive_pulse(4'b0001, 6);
        wait_valid("t6.wait", 20);
        #3;
        reset = 1'b1;
        #1;
        check("t6.async_valid", out_valid, 0);
        check("t6.async_cnt",   out_cnt,   0);
        tick(2);
        reset     = 1'b0;
        out_ready = 1'b1;
        count_valid(20, n);
        check("t6.no_stale", n, 0);
        check("t6.overrun",  overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
